// File: rtl/flipflop_if.sv
// Data-path bundle for the flipflop register: the value going in and the
// registered value coming out. The producer side takes the master modport and
// the register itself takes the slave modport.
interface flipflop_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;

   modport master (output in, input out);
   modport slave  (input in, output out);
endinterface : flipflop_if

// File: rtl/flipflop.sv
// Rising-edge D-type register with synchronous active-high reset.
// STAGES registers are chained between bus.in and bus.out, so a value sampled
// at one edge shows on bus.out STAGES-1 edges later, counting the capture edge
// as the first of the STAGES cycles. bus.out comes straight from the last
// stage's flops. There is no combinational path from bus.in or rst to bus.out.
module flipflop #(
   parameter int               WIDTH       = 1,
   parameter int               STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic       clk,
   input  logic       rst,
   flipflop_if.slave  bus
);

   // One WIDTH-bit register per stage. Index 0 captures bus.in, and the last
   // index drives bus.out.
   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift the chain forward on every edge. A reset edge loads every stage at
   // once, which discards any data in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every stage is reset, not only the output one. After reset,
         // bus.out must read RESET_VALUE until fresh data has travelled the
         // whole chain, so no stage may hold stale data.
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= RESET_VALUE;
         end
      end else begin
         // NOTE: non-blocking assignments make each stage take its
         // predecessor's value from before this edge. Blocking assignments
         // would push one input through the whole chain in a single cycle.
         stage_q[0] <= bus.in;
         for (int k = 1; k < STAGES; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign bus.out = stage_q[STAGES-1];

endmodule : flipflop

// File: tb/tb_flipflop.sv
// Directed bench for flipflop. It exercises two instances:
//  - u_bit:  default 1-bit, single-stage register (timeline below)
//  - u_pipe: 8-bit, 3-stage register that resets to 8'hA5
// The clock period is 10 ns and the first rising edge is at 5 ns.
`timescale 1ns/1ps

module tb_flipflop;

   logic clk;
   logic rst;
   logic rst_p;

   int tests_run;
   int tests_failed;

   flipflop_if #(.WIDTH(1)) bus_bit ();
   flipflop_if #(.WIDTH(8)) bus_pipe ();

   flipflop u_bit (
      .clk (clk),
      .rst (rst),
      .bus (bus_bit)
   );

   flipflop #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5)
   ) u_pipe (
      .clk (clk),
      .rst (rst_p),
      .bus (bus_pipe)
   );

   // Free-running clock: low at time 0, rising at 5, 15, 25 ns, and so on.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reset capture: rst=1 and in=0 at the 5 ns edge give out=0. Ends at 12 ns.
   task automatic test_reset();
      @(posedge clk);                       // 5 ns
      #1;
      tests_run++;
      if (bus_bit.out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_capture: out=%b expected=%b", bus_bit.out, 1'b0);
      end
      #6;                                   // 12 ns
   endtask

   // Data follow: out tracks in with one cycle of latency. Ends at 42 ns.
   task automatic test_data_follow();
      logic exp_v [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         rst        = 1'b0;
         bus_bit.in = exp_v[i];             // 12, 22, 32 ns
         @(posedge clk);                    // 15, 25, 35 ns
         #1;
         tests_run++;
         if (bus_bit.out !== exp_v[i]) begin
            tests_failed++;
            $display("FAIL data_follow[%0d]: out=%b expected=%b", i, bus_bit.out, exp_v[i]);
         end
         #6;
      end
   endtask

   // Reset overrides data: rst=1 with in=1 clears out. Releasing rst with
   // in=0 keeps out at 0. Ends at 62 ns.
   task automatic test_reset_override();
      rst        = 1'b1;                    // 42 ns, in is still 1
      bus_bit.in = 1'b1;
      @(posedge clk);                       // 45 ns
      #1;
      tests_run++;
      if (bus_bit.out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_override: out=%b expected=%b", bus_bit.out, 1'b0);
      end
      #6;
      rst        = 1'b0;                    // 52 ns
      bus_bit.in = 1'b0;
      @(posedge clk);                       // 55 ns
      #1;
      tests_run++;
      if (bus_bit.out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: out=%b expected=%b", bus_bit.out, 1'b0);
      end
      #6;                                   // 62 ns
   endtask

   // Synchronous-only reset: a 2 ns rst pulse between edges leaves out at 1,
   // both during the pulse and after the next edge samples rst=0.
   task automatic test_sync_only();
      bus_bit.in = 1'b1;                    // 62 ns
      @(posedge clk);                       // 65 ns
      #1;
      tests_run++;
      if (bus_bit.out !== 1'b1) begin
         tests_failed++;
         $display("FAIL sync_setup: out=%b expected=%b", bus_bit.out, 1'b1);
      end
      #1  rst = 1'b1;                       // 67 ns
      #1;                                   // 68 ns, mid-pulse
      tests_run++;
      if (bus_bit.out !== 1'b1) begin
         tests_failed++;
         $display("FAIL sync_mid_pulse: out=%b expected=%b", bus_bit.out, 1'b1);
      end
      #1  rst = 1'b0;                       // 69 ns
      @(posedge clk);                       // 75 ns
      #1;
      tests_run++;
      if (bus_bit.out !== 1'b1) begin
         tests_failed++;
         $display("FAIL sync_after_edge: out=%b expected=%b", bus_bit.out, 1'b1);
      end
   endtask

   // Pipelined variant: 3 stages, reset value A5. A value driven before edge
   // e appears on out after edge e+2. A reset at edge 6 drops the in-flight
   // values 04 and 05.
   task automatic test_pipeline();
      logic       vec_rst [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] vec_in  [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      logic [7:0] vec_out [11] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03,
                                   8'hA5, 8'hA5, 8'hA5, 8'h07, 8'h08};
      for (int e = 0; e < 11; e++) begin
         rst_p       = vec_rst[e];
         bus_pipe.in = vec_in[e];
         @(posedge clk);
         #1;
         tests_run++;
         if (bus_pipe.out !== vec_out[e]) begin
            tests_failed++;
            $display("FAIL pipeline_edge%0d: out=%h expected=%h", e, bus_pipe.out, vec_out[e]);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus_bit.in   = 1'b0;
      rst_p        = 1'b1;
      bus_pipe.in  = 8'h00;

      test_reset();
      test_data_follow();
      test_reset_override();
      test_sync_only();
      test_pipeline();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_flipflop
